// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - condition check, NZCV flag register and write gating for the multicycle ARM controller
// Also keeps saturating counts of executed and skipped instructions.
module cond_logic #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             NextPC,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             IRWrite,
   input  logic             cnt_clr,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [3:0]       Flags,
   output logic             CondEx,
   output logic [CNT_W-1:0] exec_cnt,
   output logic [CNT_W-1:0] skip_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic       condexreg;
   logic       decode_pend;
   logic [1:0] flagwrite;
   logic       n, z, c, v;

   assign {n, z, c, v} = Flags;

   // Evaluated against the stored flags only, never the live ALU flags.
   always_comb begin
      CondEx = 1'b1;
      case (Cond)
         4'd0:  CondEx = z;
         4'd1:  CondEx = ~z;
         4'd2:  CondEx = c;
         4'd3:  CondEx = ~c;
         4'd4:  CondEx = n;
         4'd5:  CondEx = ~n;
         4'd6:  CondEx = v;
         4'd7:  CondEx = ~v;
         4'd8:  CondEx = c & ~z;
         4'd9:  CondEx = ~c | z;
         4'd10: CondEx = (n == v);
         4'd11: CondEx = (n != v);
         4'd12: CondEx = ~z & (n == v);
         4'd13: CondEx = z | (n != v);
         default: CondEx = 1'b1;
      endcase
   end

   assign flagwrite = FlagW & {2{CondEx}};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Flags       <= 4'b0000;
         condexreg   <= 1'b0;
         decode_pend <= 1'b0;
      end else begin
         if (flagwrite[1]) Flags[3:2] <= ALUFlags[3:2];
         if (flagwrite[0]) Flags[1:0] <= ALUFlags[1:0];
         condexreg   <= CondEx;
         decode_pend <= IRWrite;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exec_cnt <= '0;
         skip_cnt <= '0;
      end else if (cnt_clr) begin
         exec_cnt <= '0;
         skip_cnt <= '0;
      end else if (decode_pend) begin
         if (CondEx) begin
            if (exec_cnt != CNT_MAX) exec_cnt <= exec_cnt + CNT_ONE;
         end else begin
            if (skip_cnt != CNT_MAX) skip_cnt <= skip_cnt + CNT_ONE;
         end
      end
   end

   // Strobes are held low for as long as reset is asserted, even with NextPC high.
   assign PCWrite  = reset & ((PCS & condexreg) | NextPC);
   assign RegWrite = reset & RegW & condexreg;
   assign MemWrite = reset & MemW & condexreg;

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - self-checking bench for cond_logic with a flag/counter reference model
module tb_cond_logic;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  Cond = 4'd14;
   logic [3:0]  ALUFlags = 4'd0;
   logic [1:0]  FlagW = 2'b00;
   logic        PCS = 1'b0, NextPC = 1'b0, RegW = 1'b0, MemW = 1'b0;
   logic        IRWrite = 1'b0, cnt_clr = 1'b0;
   logic        PCWrite, RegWrite, MemWrite, CondEx;
   logic [3:0]  Flags;
   logic [15:0] exec_cnt, skip_cnt;
   logic        PCWrite2, RegWrite2, MemWrite2, CondEx2;
   logic [3:0]  Flags2;
   logic [1:0]  exec_cnt2, skip_cnt2;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [3:0] mflags;
   bit         mcer, mpend;
   int         mexec, mskip, mexec2, mskip2;

   cond_logic #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
      .cnt_clr(cnt_clr), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .Flags(Flags), .CondEx(CondEx), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
   );

   cond_logic #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
      .cnt_clr(cnt_clr), .PCWrite(PCWrite2), .RegWrite(RegWrite2), .MemWrite(MemWrite2),
      .Flags(Flags2), .CondEx(CondEx2), .exec_cnt(exec_cnt2), .skip_cnt(skip_cnt2)
   );

   always #5 clk = ~clk;

   function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
      bit nf, zf, cf, vf;
      nf = f[3]; zf = f[2]; cf = f[1]; vf = f[0];
      unique case (cc)
         0: return zf;              1: return !zf;
         2: return cf;              3: return !cf;
         4: return nf;              5: return !nf;
         6: return vf;              7: return !vf;
         8: return cf && !zf;       9: return !(cf && !zf);
         10: return nf == vf;      11: return !(nf == vf);
         12: return !zf && nf == vf; 13: return !(!zf && nf == vf);
         default: return 1'b1;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int val, input int max);
      return (val >= max) ? max : val + 1;
   endfunction

   task automatic model_reset();
      mflags = 4'd0; mcer = 0; mpend = 0;
      mexec = 0; mskip = 0; mexec2 = 0; mskip2 = 0;
   endtask

   // compare at negedge, then advance the model on the posedge
   task automatic cycle();
      bit cex;
      @(negedge clk);
      cex = cond_ok(Cond, mflags);
      check("condex", 32'(CondEx), 32'(cex));
      check("flags", 32'(Flags), 32'(mflags));
      check("pcwrite", 32'(PCWrite), 32'(reset && ((PCS && mcer) || NextPC)));
      check("regwrite", 32'(RegWrite), 32'(reset && RegW && mcer));
      check("memwrite", 32'(MemWrite), 32'(reset && MemW && mcer));
      check("exec_cnt", 32'(exec_cnt), 32'(mexec));
      check("skip_cnt", 32'(skip_cnt), 32'(mskip));
      check("exec_cnt2", 32'(exec_cnt2), 32'(mexec2));
      check("skip_cnt2", 32'(skip_cnt2), 32'(mskip2));
      @(posedge clk);
      if (reset) begin
         if (cnt_clr) begin
            mexec = 0; mskip = 0; mexec2 = 0; mskip2 = 0;
         end else if (mpend) begin
            if (cex) begin mexec = sat_inc(mexec, 65535); mexec2 = sat_inc(mexec2, 3); end
            else     begin mskip = sat_inc(mskip, 65535); mskip2 = sat_inc(mskip2, 3); end
         end
         if (FlagW[1] && cex) mflags[3:2] = ALUFlags[3:2];
         if (FlagW[0] && cex) mflags[1:0] = ALUFlags[1:0];
         mcer = cex;
         mpend = IRWrite;
      end
      #1;
   endtask

   task automatic set_flags(input logic [3:0] f);
      Cond = 4'd14; FlagW = 2'b11; ALUFlags = f;
      cycle();
      FlagW = 2'b00;
   endtask

   initial begin
      model_reset();
      // reset with every request high
      reset = 0; PCS = 1; RegW = 1; MemW = 1; NextPC = 1;
      #2;
      cycle();
      check("rst_pcwrite", 32'(PCWrite), 32'd0);
      check("rst_regwrite", 32'(RegWrite), 32'd0);
      check("rst_memwrite", 32'(MemWrite), 32'd0);
      check("rst_flags", 32'(Flags), 32'd0);
      check("rst_cnt", 32'(exec_cnt + skip_cnt), 32'd0);
      PCS = 0; RegW = 0; MemW = 0; NextPC = 0;
      reset = 1;
      cycle();

      // Z set, EQ passes then NE fails
      set_flags(4'b0100);
      check("flags_z", 32'(Flags), 32'h4);
      Cond = 4'd0; RegW = 1; #1;
      check("eq_condex", 32'(CondEx), 32'd1);
      cycle();
      check("eq_regwrite", 32'(RegWrite), 32'd1);
      Cond = 4'd1; #1;
      check("ne_condex", 32'(CondEx), 32'd0);
      cycle();
      check("ne_regwrite", 32'(RegWrite), 32'd0);
      RegW = 0;

      // full flag write, then GE
      set_flags(4'b1001);
      check("flags_1001", 32'(Flags), 32'h9);
      Cond = 4'd10; #1;
      check("ge_condex", 32'(CondEx), 32'd1);
      cycle();
      // partial write: only C,V updated
      Cond = 4'd14; FlagW = 2'b01; ALUFlags = 4'b0110;
      cycle();
      FlagW = 2'b00;
      check("flags_partial", 32'(Flags), 32'hA);

      // failed condition blocks the flag write
      set_flags(4'b0000);
      Cond = 4'd0; FlagW = 2'b11; ALUFlags = 4'b0100;
      cycle();
      FlagW = 2'b00;
      check("flags_blocked", 32'(Flags), 32'h0);

      // NextPC ungated, PCS gated by CondExReg
      Cond = 4'd0; NextPC = 1; PCS = 0;
      cycle();
      check("nextpc_pcwrite", 32'(PCWrite), 32'd1);
      NextPC = 0; PCS = 1; #1;
      check("pcs_blocked", 32'(PCWrite), 32'd0);
      MemW = 1;
      cycle();
      PCS = 0; MemW = 0;

      // condition sweep over all flag patterns, with alternating fetches
      for (int f = 0; f < 16; f++) begin
         set_flags(4'(f));
         for (int c = 0; c < 16; c++) begin
            Cond = 4'(c); IRWrite = c[0]; RegW = c[1]; MemW = c[2]; PCS = c[3];
            cycle();
         end
      end
      IRWrite = 0; RegW = 0; MemW = 0; PCS = 0;
      cycle();

      // saturation on the 2-bit counter
      cnt_clr = 1; cycle(); cnt_clr = 0;
      Cond = 4'd14;
      for (int i = 0; i < 5; i++) begin
         IRWrite = 1; cycle();
         IRWrite = 0; cycle();
      end
      check("sat_exec2", 32'(exec_cnt2), 32'd3);
      check("sat_exec16", 32'(exec_cnt), 32'd5);
      // consecutive fetches count once each
      IRWrite = 1; repeat (3) cycle();
      IRWrite = 0; cycle();
      check("held_exec16", 32'(exec_cnt), 32'd8);
      // clear beats a pending increment
      IRWrite = 1; cycle();
      IRWrite = 0; cnt_clr = 1; cycle();
      cnt_clr = 0;
      check("clr_exec2", 32'(exec_cnt2), 32'd0);
      check("clr_exec16", 32'(exec_cnt), 32'd0);

      // reset mid-instruction drops the pending count
      set_flags(4'b0000);
      Cond = 4'd0; IRWrite = 1; cycle();
      IRWrite = 0; reset = 0; model_reset();
      cycle();
      reset = 1; RegW = 1; Cond = 4'd14; #1;
      check("post_rst_regwrite", 32'(RegWrite), 32'd0);
      cycle();
      cycle();
      check("post_rst_skip", 32'(skip_cnt), 32'd0);
      RegW = 0;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
